// File: rtl/lcd_spi_pkg.sv
// Shared definitions for the LCD SPI path: panel opcodes and decoder state encoding.
package lcd_spi_pkg;

  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_RASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;
  localparam logic [7:0] OP_SLPIN   = 8'h10;
  localparam logic [7:0] OP_SLPOUT  = 8'h11;
  localparam logic [7:0] OP_DISPOFF = 8'h28;
  localparam logic [7:0] OP_DISPON  = 8'h29;

  typedef enum logic [2:0] {
    ST_CMD   = 3'd0,
    ST_CASET = 3'd1,
    ST_RASET = 3'd2,
    ST_RAMWR = 3'd3,
    ST_SKIP  = 3'd4
  } dec_state_t;

endpackage

// File: rtl/lcd_spi_deser.sv
// SPI receive front end: optional input synchronizers, SCL rising-edge detect
// and MSB-first byte assembly, producing a one-clock {dc, byte} strobe.
module lcd_spi_deser #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       scl,
  input  logic       sda,
  input  logic       dc,
  output logic       byte_valid,
  output logic       byte_dc,
  output logic [7:0] byte_data
);

  logic [3:0] pin_raw;
  logic [3:0] pin_s;
  logic       s_cs_n, s_scl, s_sda, s_dc;
  logic       scl_prev;
  logic       scl_rise;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;

  assign pin_raw = {dc, sda, scl, cs_n};

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign pin_s = pin_raw;
    end else begin : g_sync
      logic [3:0] stage [SYNC_STAGES];
      // chip select resets deasserted so nothing is captured until the source drives it
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= 4'b0001;
        end else begin
          stage[0] <= pin_raw;
          for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
        end
      end
      assign pin_s = stage[SYNC_STAGES-1];
    end
  endgenerate

  assign {s_dc, s_sda, s_scl, s_cs_n} = pin_s;
  assign scl_rise = s_scl & ~scl_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_prev   <= 1'b1;
      bit_cnt    <= 3'd0;
      shreg      <= 7'd0;
      byte_valid <= 1'b0;
      byte_dc    <= 1'b0;
      byte_data  <= 8'd0;
    end else begin
      scl_prev   <= s_scl;
      byte_valid <= 1'b0;
      if (s_cs_n) begin
        bit_cnt <= 3'd0;
      end else if (scl_rise) begin
        shreg <= {shreg[5:0], s_sda};
        if (bit_cnt == 3'd7) begin
          bit_cnt    <= 3'd0;
          byte_valid <= 1'b1;
          byte_dc    <= s_dc;
          byte_data  <= {shreg, s_sda};
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_spi_sink.sv
// Receive-side model of the TFT panel controller: decodes the command stream
// and emits RGB565 pixel writes with an auto-incrementing window cursor.
//   state    | meaning
//   ST_CMD   | idle, waiting for a command byte
//   ST_CASET | collecting 4 column-window parameters
//   ST_RASET | collecting 4 row-window parameters
//   ST_RAMWR | pixel stream, two bytes per pixel
//   ST_SKIP  | unknown opcode, parameters ignored
module lcd_spi_sink #(
  parameter int LCD_W       = 132,
  parameter int LCD_H       = 162,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_cs_n,
  input  logic        spi_scl,
  input  logic        spi_sda,
  input  logic        spi_dc,
  output logic        pix_valid,
  output logic [7:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic        frame_done,
  output logic        disp_on,
  output logic        sleep_out
);
  import lcd_spi_pkg::*;

  localparam logic [7:0] XE_RST = 8'(LCD_W - 1);
  localparam logic [7:0] YE_RST = 8'(LCD_H - 1);

  logic       byte_valid, byte_dc;
  logic [7:0] byte_data;

  dec_state_t state, state_nxt;
  logic [7:0]  xs, xe, ys, ye, cur_x, cur_y, p_start, hold;
  logic [7:0]  xs_nxt, xe_nxt, ys_nxt, ye_nxt, cur_x_nxt, cur_y_nxt, p_start_nxt, hold_nxt;
  logic [1:0]  p_idx, p_idx_nxt;
  logic        hi_next, hi_next_nxt;
  logic        pix_valid_nxt, cmd_valid_nxt, frame_done_nxt, disp_on_nxt, sleep_out_nxt;
  logic [7:0]  pix_x_nxt, pix_y_nxt, cmd_code_nxt;
  logic [15:0] pix_data_nxt;

  lcd_spi_deser #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
    .clk        (clk),
    .rst        (rst),
    .cs_n       (spi_cs_n),
    .scl        (spi_scl),
    .sda        (spi_sda),
    .dc         (spi_dc),
    .byte_valid (byte_valid),
    .byte_dc    (byte_dc),
    .byte_data  (byte_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_CMD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (byte_valid) begin
      if (!byte_dc) begin
        unique case (byte_data)
          OP_CASET: state_nxt = ST_CASET;
          OP_RASET: state_nxt = ST_RASET;
          OP_RAMWR: state_nxt = ST_RAMWR;
          OP_SLPIN, OP_SLPOUT, OP_DISPOFF, OP_DISPON: state_nxt = ST_CMD;
          default:  state_nxt = ST_SKIP;
        endcase
      end else if ((state == ST_CASET || state == ST_RASET) && p_idx == 2'd3) begin
        state_nxt = ST_CMD;
      end
    end
  end

  always_comb begin
    xs_nxt = xs;  xe_nxt = xe;  ys_nxt = ys;  ye_nxt = ye;
    cur_x_nxt = cur_x;  cur_y_nxt = cur_y;
    p_start_nxt = p_start;  p_idx_nxt = p_idx;
    hold_nxt = hold;  hi_next_nxt = hi_next;
    pix_valid_nxt = 1'b0;  cmd_valid_nxt = 1'b0;  frame_done_nxt = 1'b0;
    pix_x_nxt = pix_x;  pix_y_nxt = pix_y;  pix_data_nxt = pix_data;
    cmd_code_nxt = cmd_code;  disp_on_nxt = disp_on;  sleep_out_nxt = sleep_out;
    if (byte_valid) begin
      if (!byte_dc) begin
        // any command aborts parameter collection and drops a dangling high byte
        cmd_valid_nxt = 1'b1;
        cmd_code_nxt  = byte_data;
        p_idx_nxt     = 2'd0;
        hi_next_nxt   = 1'b1;
        unique case (byte_data)
          OP_RAMWR:   begin cur_x_nxt = xs; cur_y_nxt = ys; end
          OP_SLPIN:   sleep_out_nxt = 1'b0;
          OP_SLPOUT:  sleep_out_nxt = 1'b1;
          OP_DISPOFF: disp_on_nxt   = 1'b0;
          OP_DISPON:  disp_on_nxt   = 1'b1;
          default: ;
        endcase
      end else begin
        unique case (state)
          ST_CASET, ST_RASET: begin
            p_idx_nxt = p_idx + 2'd1;
            if (p_idx == 2'd1) p_start_nxt = byte_data;
            if (p_idx == 2'd3) begin
              if (state == ST_CASET) begin xs_nxt = p_start; xe_nxt = byte_data; end
              else                   begin ys_nxt = p_start; ye_nxt = byte_data; end
            end
          end
          ST_RAMWR: begin
            if (hi_next) begin
              hold_nxt    = byte_data;
              hi_next_nxt = 1'b0;
            end else begin
              hi_next_nxt    = 1'b1;
              pix_valid_nxt  = 1'b1;
              pix_x_nxt      = cur_x;
              pix_y_nxt      = cur_y;
              pix_data_nxt   = {hold, byte_data};
              frame_done_nxt = (cur_x == xe) && (cur_y == ye);
              if (cur_x == xe) begin
                cur_x_nxt = xs;
                cur_y_nxt = (cur_y == ye) ? ys : cur_y + 8'd1;
              end else begin
                cur_x_nxt = cur_x + 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xs <= 8'd0;  xe <= XE_RST;  ys <= 8'd0;  ye <= YE_RST;
      cur_x <= 8'd0;  cur_y <= 8'd0;
      p_start <= 8'd0;  p_idx <= 2'd0;  hold <= 8'd0;  hi_next <= 1'b1;
      pix_valid <= 1'b0;  pix_x <= 8'd0;  pix_y <= 8'd0;  pix_data <= 16'd0;
      cmd_valid <= 1'b0;  cmd_code <= 8'd0;  frame_done <= 1'b0;
      disp_on <= 1'b0;  sleep_out <= 1'b0;
    end else begin
      xs <= xs_nxt;  xe <= xe_nxt;  ys <= ys_nxt;  ye <= ye_nxt;
      cur_x <= cur_x_nxt;  cur_y <= cur_y_nxt;
      p_start <= p_start_nxt;  p_idx <= p_idx_nxt;  hold <= hold_nxt;  hi_next <= hi_next_nxt;
      pix_valid <= pix_valid_nxt;  pix_x <= pix_x_nxt;  pix_y <= pix_y_nxt;  pix_data <= pix_data_nxt;
      cmd_valid <= cmd_valid_nxt;  cmd_code <= cmd_code_nxt;  frame_done <= frame_done_nxt;
      disp_on <= disp_on_nxt;  sleep_out <= sleep_out_nxt;
    end
  end

endmodule
